// File: rtl/io_bus_cycle.sv
// I/O bus cycle sequencer (IDLE/T1/T2/TW/T3) driven by XOTR phase strobes.
// Define IO_BUS_CYCLE_WAIT_EN to honour notWAIT with a stalled-TW timeout counter.
module io_bus_cycle (
    input  logic        CLK,
    input  logic        notRESET,
    input  logic        PC_I0,
    input  logic        PC_I1,
    input  logic        PC_I2,
    input  logic        PC_I3,
    input  logic        PC_O0,
    input  logic        PC_O1,
    input  logic        PC_O2,
    input  logic        PC_O3,
    input  logic        PI_SelectAd_BC,
    input  logic [15:0] AdIn,
    input  logic [7:0]  DtIn,
    input  logic [7:0]  DataBus_In,
    input  logic        notWAIT,
    output logic [15:0] Addr,
    output logic [7:0]  DataBus_Out,
    output logic        DataBus_OE,
    output logic        notIORQ,
    output logic        notRD,
    output logic        notWR,
    output logic [7:0]  InData,
    output logic        InValid,
    output logic        Stall,
    output logic        SeqError
);

    typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3} state_e;

    state_e     state_q, state_d;
    logic       dir_q, dir_d;  // 1 = OUT cycle
    logic       err_set, start_cycle, latch_in, bus_active, wait_expired;
    logic [3:1] ph_same, ph_opp;

    assign ph_same = dir_q ? {PC_O3, PC_O2, PC_O1} : {PC_I3, PC_I2, PC_I1};
    assign ph_opp  = dir_q ? {PC_I3, PC_I2, PC_I1} : {PC_O3, PC_O2, PC_O1};

`ifdef IO_BUS_CYCLE_WAIT_EN
    logic [7:0] wait_cnt_q;

    assign Stall = (state_q == StTw) & ~notWAIT;
    // The 255th stalled edge is the one that would bring the count to 255.
    assign wait_expired = (wait_cnt_q == 8'd254);

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            wait_cnt_q <= '0;
        end else if (state_q != StTw) begin
            wait_cnt_q <= '0;
        end else if (Stall) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end
`else
    logic unused_wait;

    assign unused_wait  = notWAIT;
    assign Stall        = 1'b0;
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        err_set     = 1'b0;
        start_cycle = 1'b0;
        latch_in    = 1'b0;
        case (state_q)
            StIdle, StT3: begin
                state_d = StIdle;
                if (PC_I0 ^ PC_O0) begin
                    state_d     = StT1;
                    dir_d       = PC_O0;
                    start_cycle = 1'b1;
                end else if (PC_I0 & PC_O0 & (state_q == StIdle)) begin
                    err_set = 1'b1;
                end
            end
            StT1: begin
                if (ph_same[1] & ~ph_opp[1]) begin
                    state_d = StT2;
                end else begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end
            end
            StT2: begin
                if (ph_same[2] & ~ph_opp[2]) begin
                    state_d = StTw;
                end else begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end
            end
            StTw: begin
                if (Stall) begin
                    if (wait_expired) begin
                        state_d = StIdle;
                        err_set = 1'b1;
                    end
                end else if (ph_same[3] & ~ph_opp[3]) begin
                    state_d  = StT3;
                    latch_in = ~dir_q;
                end else begin
                    state_d = StIdle;
                    err_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_active = (state_d == StT2) | (state_d == StTw);

    // Strobes are decoded from the next state so they come straight from flops.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_q     <= StIdle;
            dir_q       <= 1'b0;
            notIORQ     <= 1'b1;
            notRD       <= 1'b1;
            notWR       <= 1'b1;
            DataBus_OE  <= 1'b0;
            InValid     <= 1'b0;
            Addr        <= '0;
            DataBus_Out <= '0;
            InData      <= '0;
            SeqError    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            notIORQ    <= ~bus_active;
            notRD      <= ~(bus_active & ~dir_d);
            notWR      <= ~(bus_active & dir_d);
            DataBus_OE <= (state_d != StIdle) & dir_d;
            InValid    <= (state_d == StT3) & ~dir_d;
            if (start_cycle & PI_SelectAd_BC) Addr <= AdIn;
            if (start_cycle & PC_O0) DataBus_Out <= DtIn;
            if (latch_in) InData <= DataBus_In;
            if (err_set) SeqError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_bus_cycle.sv
// Self-checking bench for io_bus_cycle: directed cases plus random transactions
// whose expected bus timing is derived from each transaction's position in its cycle.
module tb_io_bus_cycle;

    logic        CLK = 1'b0;
    logic        notRESET;
    logic [3:0]  pc_i, pc_o;
    logic        PI_SelectAd_BC;
    logic [15:0] AdIn;
    logic [7:0]  DtIn, DataBus_In;
    logic        notWAIT;
    logic [15:0] Addr;
    logic [7:0]  DataBus_Out, InData;
    logic        DataBus_OE, notIORQ, notRD, notWR, InValid, Stall, SeqError;

    int n_cmp = 0;
    int n_err = 0;

    // Reference expectations for the latched outputs.
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout, exp_in;
    logic        exp_err;

    always #5 CLK = ~CLK;

    io_bus_cycle dut (
        .CLK(CLK), .notRESET(notRESET),
        .PC_I0(pc_i[0]), .PC_I1(pc_i[1]), .PC_I2(pc_i[2]), .PC_I3(pc_i[3]),
        .PC_O0(pc_o[0]), .PC_O1(pc_o[1]), .PC_O2(pc_o[2]), .PC_O3(pc_o[3]),
        .PI_SelectAd_BC(PI_SelectAd_BC), .AdIn(AdIn), .DtIn(DtIn),
        .DataBus_In(DataBus_In), .notWAIT(notWAIT),
        .Addr(Addr), .DataBus_Out(DataBus_Out), .DataBus_OE(DataBus_OE),
        .notIORQ(notIORQ), .notRD(notRD), .notWR(notWR),
        .InData(InData), .InValid(InValid), .Stall(Stall), .SeqError(SeqError)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input bit iorq_lo, input bit rd_lo,
                           input bit wr_lo, input bit oe, input bit inv, input bit stall);
        chk({tag, ".notIORQ"}, {31'd0, notIORQ}, {31'd0, ~iorq_lo});
        chk({tag, ".notRD"}, {31'd0, notRD}, {31'd0, ~rd_lo});
        chk({tag, ".notWR"}, {31'd0, notWR}, {31'd0, ~wr_lo});
        chk({tag, ".OE"}, {31'd0, DataBus_OE}, {31'd0, oe});
        chk({tag, ".InValid"}, {31'd0, InValid}, {31'd0, inv});
        chk({tag, ".Stall"}, {31'd0, Stall}, {31'd0, stall});
        chk({tag, ".Addr"}, {16'd0, Addr}, {16'd0, exp_addr});
        chk({tag, ".DataBus_Out"}, {24'd0, DataBus_Out}, {24'd0, exp_dout});
        chk({tag, ".InData"}, {24'd0, InData}, {24'd0, exp_in});
        chk({tag, ".SeqError"}, {31'd0, SeqError}, {31'd0, exp_err});
    endtask

    function automatic bit idle_wait();
`ifdef IO_BUS_CYCLE_WAIT_EN
        return 1'b1;
`else
        return 1'($urandom % 2);
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        pc_i       = '0;
        pc_o       = '0;
        notWAIT    = idle_wait();
        DataBus_In = 8'($urandom);
        AdIn       = 16'($urandom);
        DtIn       = 8'($urandom);
    endtask

    task automatic drive_pc(input bit out, input int ph);
        pc_i = '0;
        pc_o = '0;
        if (out) pc_o[ph] = 1'b1;
        else     pc_i[ph] = 1'b1;
    endtask

    task automatic model_reset();
        exp_addr = '0;
        exp_dout = '0;
        exp_in   = '0;
        exp_err  = 1'b0;
    endtask

    // One bus cycle; PC_x0 is presented for the coming edge. bad_phase (1..3)
    // replaces that phase's strobe with the opposite-direction one.
    task automatic txn(input bit out, input logic [15:0] a, input logic [7:0] dout,
                       input logic [7:0] din, input int waits, input int bad_phase);
        drive_pc(out, 0);
        AdIn    = a;
        DtIn    = dout;
        notWAIT = idle_wait();
        tick();
        exp_addr = a;
        if (out) exp_dout = dout;
        chk_bus("t1", 0, 0, 0, out, 0, 0);
        AdIn = 16'($urandom);
        DtIn = 8'($urandom);
        for (int p = 1; p <= 3; p++) begin
            if (p == bad_phase) drive_pc(!out, p);
            else                drive_pc(out, p);
            notWAIT    = idle_wait();
            DataBus_In = 8'($urandom);
            if (p == 3 && p != bad_phase) begin
                for (int w = 0; w < waits; w++) begin
                    notWAIT = 1'b0;
                    #1;
                    chk({"stall_comb"}, {31'd0, Stall}, 32'd1);
                    tick();
                    chk_bus("tw_wait", 1, !out, out, out, 0, 1);
                end
                notWAIT    = 1'b1;
                DataBus_In = din;
            end
            tick();
            if (p == bad_phase) begin
                exp_err = 1'b1;
                chk_bus("seq_err", 0, 0, 0, 0, 0, 0);
                set_idle();
                return;
            end
            if (p < 3) begin
                chk_bus(p == 1 ? "t2" : "tw", 1, !out, out, out, 0, 0);
            end else begin
                if (!out) exp_in = din;
                chk_bus("t3", 0, 0, 0, out, !out, 0);
            end
        end
        set_idle();
    endtask

    task automatic idle_tick();
        set_idle();
        tick();
        chk_bus("idle", 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        notRESET       = 1'b0;
        PI_SelectAd_BC = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_bus("reset", 0, 0, 0, 0, 0, 0);
        #3 notRESET = 1'b1;
        idle_tick();

        // Reset pulse in TW aborts the cycle without latching InData.
        drive_pc(0, 0);
        AdIn = 16'hBEEF;
        tick();
        exp_addr = 16'hBEEF;
        drive_pc(0, 1);
        tick();
        drive_pc(0, 2);
        tick();
        chk_bus("pre_rst_tw", 1, 1, 0, 0, 0, 0);
        drive_pc(0, 3);
        DataBus_In = 8'h77;
        #1 notRESET = 1'b0;
        #1;
        model_reset();
        chk_bus("mid_rst", 0, 0, 0, 0, 0, 0);
        #2 notRESET = 1'b1;
        set_idle();
        tick();
        chk_bus("post_rst", 0, 0, 0, 0, 0, 0);

        // Nominal IN and OUT cycles.
        txn(0, 16'h12FE, 8'h00, 8'hA5, 0, 0);
        idle_tick();
        txn(1, 16'h0040, 8'h3C, 8'h5A, 0, 0);
        idle_tick();

`ifdef IO_BUS_CYCLE_WAIT_EN
        txn(0, 16'h2222, 8'h00, 8'hC3, 3, 0);
        idle_tick();
        // Wait held low long enough to expire the timeout.
        drive_pc(0, 0);
        AdIn = 16'h4455;
        tick();
        exp_addr = 16'h4455;
        drive_pc(0, 1);
        tick();
        drive_pc(0, 2);
        tick();
        drive_pc(0, 3);
        notWAIT    = 1'b0;
        DataBus_In = 8'h99;
        repeat (254) tick();
        chk_bus("wait_254", 1, 1, 0, 0, 0, 1);
        tick();
        exp_err = 1'b1;
        chk_bus("wait_timeout", 0, 0, 0, 0, 0, 0);
        idle_tick();
`endif

        // Wrong-direction phase-1 strobe, then a clean cycle with SeqError held.
        txn(0, 16'h3344, 8'h00, 8'h11, 0, 1);
        txn(0, 16'h5566, 8'h00, 8'h6E, 0, 0);
        idle_tick();

        // Both phase-0 strobes in IDLE.
        pc_i[0] = 1'b1;
        pc_o[0] = 1'b1;
        AdIn    = 16'hFFFF;
        tick();
        chk_bus("both_pc0", 0, 0, 0, 0, 0, 0);
        idle_tick();

        // Back-to-back cycles: next PC_x0 is presented during T3.
        txn(0, 16'h0101, 8'h00, 8'h81, 0, 0);
        txn(0, 16'h0202, 8'h00, 8'h82, 0, 0);
        txn(1, 16'h0303, 8'h83, 8'h00, 0, 0);
        idle_tick();

        for (int n = 0; n < 40; n++) begin
            bit out;
            int waits, bad;
            out = 1'($urandom % 2);
`ifdef IO_BUS_CYCLE_WAIT_EN
            waits = int'($urandom_range(0, 3));
`else
            waits = 0;
`endif
            bad = ($urandom % 6 == 0) ? int'($urandom_range(1, 3)) : 0;
            txn(out, 16'($urandom), 8'($urandom), 8'($urandom), waits, bad);
            if ($urandom % 2 == 0) idle_tick();
        end
        idle_tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_bus_cycle.md
IO_BUS_CYCLE -- requirements
Module: io_bus_cycle

Interface
REQ-001 SHALL have port CLK  input  1  single system clock, rising-edge.
REQ-002 SHALL have port notRESET  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports PC_I0..PC_I3  input  1 each  IN-cycle phase strobes from the XOTR 01xxx00 decoder.
REQ-004 SHALL have ports PC_O0..PC_O3  input  1 each  OUT-cycle phase strobes from the same decoder.
REQ-005 SHALL have port PI_SelectAd_BC  input  1  BC address select; AdIn is valid while high.
REQ-006 SHALL have ports AdIn  input  16  port address (BC); DtIn  input  8  register data for OUT.
REQ-007 SHALL have ports DataBus_In  input  8  external data bus; notWAIT  input  1  external wait request, active-low.
REQ-008 SHALL have ports Addr  output  16  latched port address; DataBus_Out  output  8  latched OUT data; DataBus_OE  output  1  data bus drive enable.
REQ-009 SHALL have ports notIORQ, notRD, notWR  output  1 each  active-low bus strobes.
REQ-010 SHALL have ports InData  output  8  latched IN data; InValid  output  1  one-cycle data-valid pulse.
REQ-011 SHALL have ports Stall  output  1  holds the XPT counter upstream; SeqError  output  1  sticky protocol error.

Function
REQ-012 SHALL implement states IDLE, T1, T2, TW, T3 plus a direction bit (IN/OUT) captured at T1 entry.
REQ-013 IDLE or T3 + exactly one of PC_I0/PC_O0 at an edge SHALL enter T1, latch Addr<=AdIn, latch DataBus_Out<=DtIn for OUT, and set the direction bit.
REQ-014 PC_I0 and PC_O0 both high at an edge in IDLE SHALL set SeqError and stay IDLE.
REQ-015 T1 + same-direction phase-1 strobe -> T2; T2 + phase-2 -> TW; TW + phase-3 and not Stall -> T3; T3 -> IDLE, or T1 under REQ-013 (back-to-back cycles).
REQ-016 A missing expected strobe, or an opposite-direction strobe, in T1/T2/TW (TW only when Stall=0) SHALL set SeqError and return to IDLE.
REQ-017 notIORQ=0 in T2 and TW only; notRD=0 in T2/TW for IN; notWR=0 in T2/TW for OUT; all strobes SHALL be registered, with no glitches.
REQ-018 DataBus_OE=1 in T1, T2, TW, T3 for OUT; 0 otherwise.
REQ-019 The TW->T3 edge SHALL latch InData<=DataBus_In for IN; InValid=1 in T3 for IN only.
REQ-020 Latency: PC_x0 sampled at edge k -> notIORQ falls after edge k+1 -> InValid high after edge k+3 when there is no wait.
REQ-021 Addr and InData SHALL hold their values until the next latch event.
REQ-022 SeqError SHALL be sticky and cleared only by reset; once set, all strobes are deasserted and the block still accepts new cycles.

Reset
REQ-023 notRESET=0 SHALL immediately force IDLE, with notIORQ=notRD=notWR=1, DataBus_OE=0, Addr=0, DataBus_Out=0, InData=0, InValid=0, Stall=0, SeqError=0, and the wait counter at 0.
REQ-024 Reset asserted mid-cycle SHALL abort without latching InData; reset release SHALL take effect synchronously at the first edge.

Configuration
REQ-025 Macro IO_BUS_CYCLE_WAIT_EN: when defined, Stall = (state==TW) & ~notWAIT, combinationally; TW persists while Stall=1.
REQ-026 With IO_BUS_CYCLE_WAIT_EN defined, an 8-bit counter SHALL count stalled TW cycles and reset on TW entry; reaching 255 SHALL set SeqError and go to IDLE.
REQ-027 With IO_BUS_CYCLE_WAIT_EN undefined, notWAIT is ignored, Stall is tied 0, and no counter is built.

Verification
REQ-028 IN cycle, AdIn=0x12FE, DataBus_In=0xA5 at TW, notWAIT=1 -> Addr=0x12FE, notIORQ/notRD low exactly 2 cycles, InData=0xA5, InValid high 1 cycle.
REQ-029 OUT cycle, DtIn=0x3C -> DataBus_Out=0x3C, DataBus_OE high 4 cycles, notWR low 2 cycles, notRD stays 1, InValid stays 0.
REQ-030 WAIT_EN: notWAIT=0 for 3 cycles in TW -> Stall high 3 cycles, strobes low 5 cycles total, data latched after notWAIT rises.
REQ-031 WAIT_EN: notWAIT held 0 for 255 cycles -> SeqError=1, IDLE, strobes released.
REQ-032 PC_I0 followed by PC_O1 -> SeqError=1, IDLE; then a clean IN cycle completes normally while SeqError stays 1.
REQ-033 notRESET pulsed low during TW -> strobes immediately 1, InData stays 0; back-to-back PC_I0 in T3 -> T1 with no IDLE gap.
